// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares one register-file port among 4 read and 2 write
// clients, one operation per cycle, registered outputs.
// Ports: clk/rst; rd_req/rd_addr -> rd_gnt, rd_valid/rd_id/rd_data;
//        wr_req/wr_addr/wr_data -> wr_gnt; rf_re/rf_raddr, rf_we/rf_waddr/
//        rf_wdata to the register file, rf_rdata back (one cycle latency).
// Optional feature: define RF_ARB_STARVE_EN to enable the write-starvation
// counter (wait_cnt); otherwise reads strictly win over writes.
module rf_port_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          rd_req,
    input  logic [4*ADDR_W-1:0] rd_addr,
    output logic [3:0]          rd_gnt,
    output logic                rd_valid,
    output logic [1:0]          rd_id,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [1:0]          wr_req,
    input  logic [2*ADDR_W-1:0] wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic [1:0]          wr_gnt,
    output logic                rf_re,
    output logic [ADDR_W-1:0]   rf_raddr,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [DATA_W-1:0]   rf_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] rr_ptr;
    logic [1:0] rd_sel_q;
    logic [3:0] rd_el;
    logic [1:0] wr_el;
    logic       rd_found;
    logic [1:0] rd_sel;
    logic [1:0] idx;
    logic       wr_sel;
    logic       starve;

`ifdef RF_ARB_STARVE_EN
    logic [3:0] wait_cnt;
`endif

    assign rd_data = rf_rdata;
    assign rf_re   = (state == READ);
    assign rf_we   = (state == WRITE);

    always_comb begin
        // A client whose grant is currently high is being served this
        // cycle; its still-asserted request must not win again.
        rd_el    = rd_req & ~rd_gnt;
        wr_el    = wr_req & ~wr_gnt;
        rd_found = 1'b0;
        rd_sel   = 2'd0;
        idx      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!rd_found && rd_el[idx]) begin
                rd_found = 1'b1;
                rd_sel   = idx;
            end
        end
        wr_sel = ~wr_el[0];
`ifdef RF_ARB_STARVE_EN
        starve = (|wr_el) && (wait_cnt == 4'(MAX_WAIT));
`else
        starve = 1'b0;
`endif
        state_nx = IDLE;
        if (rd_found && !starve)
            state_nx = READ;
        else if (|wr_el)
            state_nx = WRITE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_gnt   <= '0;
            wr_gnt   <= '0;
            rr_ptr   <= '0;
            rd_sel_q <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rf_raddr <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nx;
            rd_gnt   <= '0;
            wr_gnt   <= '0;
            rd_valid <= (state == READ);
            if (state == READ)
                rd_id <= rd_sel_q;
            if (state_nx == READ) begin
                rd_gnt[rd_sel] <= 1'b1;
                rd_sel_q       <= rd_sel;
                rr_ptr         <= rd_sel + 2'd1;
                rf_raddr       <= rd_addr[rd_sel*ADDR_W +: ADDR_W];
            end
            if (state_nx == WRITE) begin
                wr_gnt[wr_sel] <= 1'b1;
                rf_waddr       <= wr_addr[wr_sel*ADDR_W +: ADDR_W];
                rf_wdata       <= wr_data[wr_sel*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RF_ARB_STARVE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_nx == WRITE)
            wait_cnt <= '0;
        else if ((|wr_el) && (wait_cnt != 4'(MAX_WAIT)))
            wait_cnt <= wait_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed and random stimulus for rf_port_arbiter,
// checked against a transaction-level model and a memory-backed RF.
module tb_rf_port_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    rd_req;
    logic [4*AW-1:0] rd_addr;
    logic [3:0]    rd_gnt;
    logic          rd_valid;
    logic [1:0]    rd_id;
    logic [DW-1:0] rd_data;
    logic [1:0]    wr_req;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]    wr_gnt;
    logic          rf_re;
    logic [AW-1:0] rf_raddr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    rf_port_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .MAX_WAIT(MW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .rd_valid(rd_valid),
        .rd_id   (rd_id),
        .rd_data (rd_data),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_gnt  (wr_gnt),
        .rf_re   (rf_re),
        .rf_raddr(rf_raddr),
        .rf_we   (rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file behind the arbiter
    logic [DW-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rf_rdata = '0;
    end
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        if (rf_re) rf_rdata <= mem[rf_raddr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Transaction-level model
    int          m_rr, m_wait, m_pid, m_id;
    bit          m_re, m_we, m_valid;
    bit [3:0]    m_rg;
    bit [1:0]    m_wg;
    logic [4:0]  m_ra, m_wa;
    logic [63:0] m_wd, m_pend, m_exp;
    logic [63:0] m_mem [32];

    task automatic model_reset();
        m_rr = 0; m_wait = 0; m_pid = 0; m_id = 0;
        m_re = 0; m_we = 0; m_valid = 0;
        m_rg = 0; m_wg = 0;
        m_ra = 0; m_wa = 0; m_wd = 0;
    endtask

    task automatic model_edge();
        bit [3:0] re_el;
        bit [1:0] we_el;
        bit       force_w;
        int       win;
        m_valid = m_re;
        if (m_re) begin
            m_id  = m_pid;
            m_exp = m_pend;
        end
        re_el   = rd_req & ~m_rg;
        we_el   = wr_req & ~m_wg;
        force_w = 0;
`ifdef RF_ARB_STARVE_EN
        force_w = (we_el != 0) && (m_wait == MW);
`endif
        m_re = 0; m_we = 0; m_rg = 0; m_wg = 0;
        if (re_el != 0 && !force_w) begin
            win = -1;
            for (int k = 0; k < 4; k++)
                if (win < 0 && re_el[(m_rr + k) % 4])
                    win = (m_rr + k) % 4;
            m_re      = 1;
            m_rg[win] = 1;
            m_ra      = rd_addr[win*AW +: AW];
            m_pid     = win;
            m_pend    = m_mem[m_ra];
            m_rr      = (win + 1) % 4;
        end else if (we_el != 0) begin
            win       = we_el[0] ? 0 : 1;
            m_we      = 1;
            m_wg[win] = 1;
            m_wa      = wr_addr[win*AW +: AW];
            m_wd      = wr_data[win*DW +: DW];
            m_mem[m_wa] = m_wd;
        end
`ifdef RF_ARB_STARVE_EN
        if (m_we) m_wait = 0;
        else if (we_el != 0 && m_wait < MW) m_wait++;
`endif
    endtask

    task automatic compare();
        chk("rd_gnt", 64'(rd_gnt), 64'(m_rg));
        chk("wr_gnt", 64'(wr_gnt), 64'(m_wg));
        chk("rf_re", 64'(rf_re), 64'(m_re));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_raddr", 64'(rf_raddr), 64'(m_ra));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
        chk("rf_wdata", 64'(rf_wdata), m_wd);
        chk("rd_valid", 64'(rd_valid), 64'(m_valid));
        chk("rd_id", 64'(rd_id), 64'(m_id));
        if (m_valid) chk("rd_data", rd_data, m_exp);
    endtask

    task automatic cyc(input logic [3:0] rq, input logic [1:0] wq);
        @(negedge clk);
        rd_req = rq;
        wr_req = wq;
        @(posedge clk);
        model_edge();
        #1 compare();
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_re"}, 64'(rf_re), 64'd0);
        chk({tag, "_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_gnt"}, 64'({rd_gnt, wr_gnt}), 64'd0);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_id"}, 64'(rd_id), 64'd0);
        chk({tag, "_raddr"}, 64'(rf_raddr), 64'd0);
        chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
    endtask

    logic [3:0] exp_seq [5];
    int         gnt_at;

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_exp = '0; m_pend = '0;
        rst = 1'b1;
        rd_req = '0; wr_req = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 zero_outs("reset");
        @(negedge clk) rst = 1'b0;

        // Round-robin over four held reads
        rd_addr = {5'd3, 5'd2, 5'd1, 5'd0};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 2'b00);
            chk("rr_seq", 64'(rd_gnt), 64'(exp_seq[i]));
        end
        cyc(4'b0000, 2'b00);
        cyc(4'b0000, 2'b00);

        // Two writers, fixed priority
        wr_addr = {5'd9, 5'd4};
        wr_data = {64'hBBBB, 64'hAAAA};
        cyc(4'b0000, 2'b11);
        chk("wr_first", 64'(wr_gnt), 64'b01);
        chk("wr_first_a", 64'(rf_waddr), 64'd4);
        cyc(4'b0000, 2'b11);
        chk("wr_second", 64'(wr_gnt), 64'b10);
        chk("wr_second_d", rf_wdata, 64'hBBBB);
        cyc(4'b0000, 2'b00);

        // Write then read back through client 2
        wr_addr = {5'd0, 5'd5};
        wr_data = {64'h0, 64'h1234};
        cyc(4'b0000, 2'b01);
        cyc(4'b0000, 2'b00);
        rd_addr = {5'd0, 5'd5, 5'd0, 5'd0};
        cyc(4'b0100, 2'b00);
        cyc(4'b0000, 2'b00);
        chk("rb_valid", 64'(rd_valid), 64'd1);
        chk("rb_id", 64'(rd_id), 64'd2);
        chk("rb_data", rd_data, 64'h1234);

        // Write starvation under saturating reads
        wr_addr = {5'd0, 5'd7};
        wr_data = {64'h0, 64'h77};
        gnt_at = -1;
        for (int i = 0; i < 100; i++) begin
            cyc(4'b1111, 2'b01);
            if (gnt_at < 0 && wr_gnt[0]) gnt_at = i + 1;
        end
`ifdef RF_ARB_STARVE_EN
        chk("starve_gnt", 64'(gnt_at > 0 && gnt_at <= 10), 64'd1);
`else
        chk("starve_none", 64'(gnt_at), 64'hFFFFFFFFFFFFFFFF);
`endif
        cyc(4'b0000, 2'b00);
        cyc(4'b0000, 2'b00);

        // Reset during a read strobe
        rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
        cyc(4'b0010, 2'b00);
        chk("pre_rst_re", 64'(rf_re), 64'd1);
        #1 rst = 1'b1;
        #1 zero_outs("async_rst");
        model_reset();
        @(negedge clk);
        rd_req = '0; wr_req = '0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cyc(4'b1111, 2'b00);
        chk("post_rst_gnt", 64'(rd_gnt), 64'b0001);
        cyc(4'b0000, 2'b00);
        cyc(4'b0000, 2'b00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rd_addr = 20'($urandom);
            wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            rd_req  = 4'($urandom);
            wr_req  = 2'($urandom);
            @(posedge clk);
            model_edge();
            #1 compare();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
